// File: rtl/mario_pkg.sv
// Shared types for the Mario movement blocks: tile codes, motion states and
// the controller direction decode.
package mario_pkg;

    typedef logic [7:0] tile_t;

    localparam tile_t BDR = 8'd0;
    localparam tile_t SKY = 8'd1;
    localparam tile_t BLK = 8'd2;
    localparam tile_t GND = 8'd3;
    localparam tile_t TKN = 8'd4;
    localparam tile_t CK1 = 8'd5;
    localparam tile_t CK2 = 8'd6;

    typedef enum logic [1:0] {
        STATIONARY,
        RUN,
        COAST,
        SKID
    } move_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_L,
        DIR_R
    } dir_t;

    // Tiles Mario cannot walk through.
    function automatic logic is_solid(input tile_t t);
        return (t == BLK) || (t == GND);
    endfunction

endpackage

// File: rtl/tile_column_probe.sv
// Combinational probe: is any tile row overlapped by the sprite solid in the
// given column. Rows and columns outside the map are never enumerated, so
// they read as non-solid without any negative division.
module tile_column_probe
    import mario_pkg::*;
#(
    parameter int MAP_ROWS    = 12,
    parameter int MAP_COLS    = 17,
    parameter int BLOCK_WIDTH = 40
) (
    input  tile_t [MAP_ROWS-1:0][MAP_COLS-1:0] background,
    input  int                                 col,
    input  int                                 y_top,
    input  int                                 height,
    output logic                               solid
);

    int                  y_bot;
    logic [MAP_ROWS-1:0] row_hit;

    assign y_bot = y_top + height - 1;

    // A row is spanned when its pixel band [r*BW, (r+1)*BW) meets [y_top, y_bot].
    always_comb begin
        row_hit = '0;
        for (int rr = 0; rr < MAP_ROWS; rr++)
            row_hit[rr] = (rr * BLOCK_WIDTH <= y_bot) && ((rr + 1) * BLOCK_WIDTH > y_top);
    end

    // OR together solid tiles in the requested column over the spanned rows.
    always_comb begin
        solid = 1'b0;
        for (int rr = 0; rr < MAP_ROWS; rr++)
            for (int cc = 0; cc < MAP_COLS; cc++)
                if (cc == col && row_hit[rr] && is_solid(background[rr][cc]))
                    solid = 1'b1;
    end

endmodule

// File: rtl/mario_horizontal_mover.sv
// Speed-based horizontal mover: accelerate / coast / skid state machine plus
// a per-tick position step clamped against solid tiles and the screen edges.
module mario_horizontal_mover
    import mario_pkg::*;
#(
    parameter int CHARACTER_WIDTH  = 42,
    parameter int CHARACTER_HEIGHT = 42,
    parameter int BLOCK_WIDTH      = 40,
    parameter int SCREEN_WIDTH     = 640,
    parameter int MAP_ROWS         = 12,
    parameter int MAP_COLS         = 17,
    parameter int START_X          = 100,
    parameter int MAX_SPEED        = 4,
    parameter int ACCEL_TICKS      = 6,
    parameter int DECEL_TICKS      = 3
) (
    input  logic                                 movement_clock,
    input  logic                                 reset,
    input  logic                                 tick,
    input  logic                                 left,
    input  logic                                 right,
    input  tile_t [MAP_ROWS-1:0][MAP_COLS-1:0]   background,
    input  int                                   mario_y,
    output int                                   mario_x,
    output logic [$clog2(MAX_SPEED+1)-1:0]       speed,
    output logic                                 facing_left,
    output logic                                 blocked
);

    localparam int SPD_W      = $clog2(MAX_SPEED + 1);
    localparam int SKID_TICKS = (DECEL_TICKS / 2 > 1) ? DECEL_TICKS / 2 : 1;
    localparam int CNT_MAX    = (ACCEL_TICKS > DECEL_TICKS) ? ACCEL_TICKS : DECEL_TICKS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int RIGHT_EDGE = SCREEN_WIDTH - CHARACTER_WIDTH;

    // Accel, coast and skid counting are mutually exclusive by state and the
    // count clears on every transition, so one counter serves all three.
    move_state_t      state, st_n;
    logic [CNT_W-1:0] move_cnt, cnt_n, cnt_inc;
    logic [SPD_W-1:0] spd_n;
    logic             face_n;
    dir_t             dir_req, fwd;

    int   cand_r, cand_l, col_r, col_l, probe_col, x_n;
    logic solid, clamp;

    assign dir_req = (left && !right) ? DIR_L :
                     (right && !left) ? DIR_R : DIR_NONE;
    assign fwd     = facing_left ? DIR_L : DIR_R;
    assign cnt_inc = move_cnt + CNT_W'(1);

    // Next speed / facing / state for this tick, before collision clamping.
    always_comb begin
        st_n   = state;
        spd_n  = speed;
        face_n = facing_left;
        cnt_n  = move_cnt;
        unique case (state)
            STATIONARY: begin
                if (dir_req != DIR_NONE) begin
                    face_n = (dir_req == DIR_L);
                    spd_n  = SPD_W'(1);
                    st_n   = RUN;
                    cnt_n  = '0;
                end
            end
            RUN: begin
                if (dir_req == fwd) begin
                    if (cnt_inc == CNT_W'(ACCEL_TICKS)) begin
                        cnt_n = '0;
                        if (speed != SPD_W'(MAX_SPEED))
                            spd_n = speed + SPD_W'(1);
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (dir_req == DIR_NONE) begin
                    st_n  = COAST;
                    cnt_n = '0;
                end else begin
                    st_n  = SKID;
                    cnt_n = '0;
                end
            end
            COAST: begin
                if (dir_req == fwd) begin
                    st_n  = RUN;
                    cnt_n = '0;
                end else if (dir_req != DIR_NONE) begin
                    st_n  = SKID;
                    cnt_n = '0;
                end else if (speed == '0) begin
                    st_n  = STATIONARY;
                    cnt_n = '0;
                end else if (cnt_inc == CNT_W'(DECEL_TICKS)) begin
                    spd_n = speed - SPD_W'(1);
                    cnt_n = '0;
                    if (speed == SPD_W'(1))
                        st_n = STATIONARY;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            SKID: begin
                // Skid keeps the old facing; travel reverses only once stopped.
                if (dir_req == DIR_NONE) begin
                    st_n  = COAST;
                    cnt_n = '0;
                end else if (dir_req == fwd) begin
                    st_n  = RUN;
                    cnt_n = '0;
                end else if (speed == '0) begin
                    st_n   = STATIONARY;
                    face_n = !facing_left;
                    cnt_n  = '0;
                end else if (cnt_inc == CNT_W'(SKID_TICKS)) begin
                    spd_n = speed - SPD_W'(1);
                    cnt_n = '0;
                    if (speed == SPD_W'(1)) begin
                        st_n   = STATIONARY;
                        face_n = !facing_left;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                st_n  = STATIONARY;
                cnt_n = '0;
            end
        endcase
    end

    // Candidate positions and the leading tile column in each direction.
    assign cand_r    = mario_x + int'(spd_n);
    assign cand_l    = mario_x - int'(spd_n);
    assign col_r     = (cand_r + CHARACTER_WIDTH - 1) / BLOCK_WIDTH;
    assign col_l     = (cand_l < 0) ? -1 : cand_l / BLOCK_WIDTH;
    assign probe_col = face_n ? col_l : col_r;

    tile_column_probe #(
        .MAP_ROWS   (MAP_ROWS),
        .MAP_COLS   (MAP_COLS),
        .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_probe (
        .background(background),
        .col       (probe_col),
        .y_top     (mario_y),
        .height    (CHARACTER_HEIGHT),
        .solid     (solid)
    );

    // Position step with tile and screen clamps, using the speed after this tick's update.
    always_comb begin
        x_n   = mario_x;
        clamp = 1'b0;
        if (spd_n != '0) begin
            if (face_n) begin
                if (cand_l < 0) begin
                    x_n   = 0;
                    clamp = 1'b1;
                end else if (solid) begin
                    x_n   = (col_l + 1) * BLOCK_WIDTH;
                    clamp = 1'b1;
                end else begin
                    x_n = cand_l;
                end
            end else begin
                if (solid) begin
                    x_n   = col_r * BLOCK_WIDTH - CHARACTER_WIDTH;
                    clamp = 1'b1;
                end else begin
                    x_n = cand_r;
                end
                if (x_n > RIGHT_EDGE) begin
                    x_n   = RIGHT_EDGE;
                    clamp = 1'b1;
                end
            end
        end
    end

    // State and output registers; only tick cycles advance, blocked is a one-cycle pulse.
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            state       <= STATIONARY;
            move_cnt    <= '0;
            mario_x     <= START_X;
            speed       <= '0;
            facing_left <= 1'b0;
            blocked     <= 1'b0;
        end else begin
            blocked <= 1'b0;
            if (tick) begin
                mario_x     <= x_n;
                facing_left <= face_n;
                blocked     <= clamp;
                if (clamp) begin
                    state    <= STATIONARY;
                    speed    <= '0;
                    move_cnt <= '0;
                end else begin
                    state    <= st_n;
                    speed    <= spd_n;
                    move_cnt <= cnt_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_mario_horizontal_mover.sv
// Directed bench for mario_horizontal_mover with hand-computed expectations.
module tb_mario_horizontal_mover;
    import mario_pkg::*;

    localparam int R = 12;
    localparam int C = 17;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic tick  = 1'b0;
    logic left  = 1'b0;
    logic right = 1'b0;
    tile_t [R-1:0][C-1:0] bg;
    int   y;
    int   x;
    logic [2:0] spd;
    logic fl, blk;

    int total = 0;
    int bad   = 0;

    int t1_spd [20] = '{1,1,1,1,1,1,2,2,2,2,2,2,3,3,3,3,3,3,4,4};
    int sk_spd [6]  = '{4,3,2,1,0,1};
    int sk_x   [6]  = '{44,47,49,50,50,49};
    int sk_fl  [6]  = '{0,0,0,0,1,1};
    int co_spd [7]  = '{2,2,2,1,1,1,0};
    int co_x   [7]  = '{40,38,36,35,34,33,33};

    always #5 clk = ~clk;

    mario_horizontal_mover dut (
        .movement_clock(clk),
        .reset         (rst_n),
        .tick          (tick),
        .left          (left),
        .right         (right),
        .background    (bg),
        .mario_y       (y),
        .mario_x       (x),
        .speed         (spd),
        .facing_left   (fl),
        .blocked       (blk)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One tick strobe; returns on the following negedge with outputs settled.
    task automatic tk();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        int prev;
        int found;
        int seen;

        y = 400;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                bg[r][c] = SKY;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", x, 100);
        chk("rst_spd", int'(spd), 0);
        chk("rst_fl", int'(fl), 0);
        chk("rst_blk", int'(blk), 0);
        rst_n = 1'b1;

        // Held input without tick changes nothing
        right = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_tick_x", x, 100);
        chk("no_tick_spd", int'(spd), 0);

        // 1: acceleration on an empty map
        prev = x;
        for (int i = 0; i < 20; i++) begin
            tk();
            chk($sformatf("t1_spd%0d", i), int'(spd), t1_spd[i]);
            chk($sformatf("t1_inc%0d", i), int'(x > prev), 1);
            prev = x;
        end
        chk("t1_x", x, 144);

        // 2: BLK at row 10 col 5 stops the right edge at 199
        bg[10][5] = BLK;
        tk(); chk("t2_x148", x, 148);
        tk(); chk("t2_x152", x, 152);
        tk(); chk("t2_x156", x, 156);
        chk("t2_blk_pre", int'(blk), 0);
        tk();
        chk("t2_x", x, 158);
        chk("t2_spd", int'(spd), 0);
        chk("t2_blk", int'(blk), 1);
        chk("t2_fl", int'(fl), 0);
        @(negedge clk);
        chk("t2_blk_drop", int'(blk), 0);
        chk("t2_x_hold", x, 158);
        bg[10][5] = SKY;

        // 3: left run into the screen edge
        right = 1'b0;
        left  = 1'b1;
        repeat (48) tk();
        chk("t3_x2", x, 2);
        chk("t3_spd4", int'(spd), 4);
        tk();
        chk("t3_x0", x, 0);
        chk("t3_blk", int'(blk), 1);
        chk("t3_spd0", int'(spd), 0);
        chk("t3_fl", int'(fl), 1);
        @(negedge clk);
        chk("t3_blk_drop", int'(blk), 0);
        tk();
        tk();
        chk("t3_x_stay", x, 0);

        // 4: reversal at speed 4 skids before turning
        left  = 1'b0;
        right = 1'b1;
        repeat (19) tk();
        chk("t4_x40", x, 40);
        chk("t4_spd4", int'(spd), 4);
        chk("t4_fl0", int'(fl), 0);
        right = 1'b0;
        left  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tk();
            chk($sformatf("t4_spd%0d", i), int'(spd), sk_spd[i]);
            chk($sformatf("t4_x%0d", i), x, sk_x[i]);
            chk($sformatf("t4_fl%0d", i), int'(fl), sk_fl[i]);
        end

        // 5: both held -> coast down to a stop
        repeat (6) tk();
        chk("t5_x42", x, 42);
        chk("t5_spd2", int'(spd), 2);
        right = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tk();
            chk($sformatf("t5_spd%0d", i), int'(spd), co_spd[i]);
            chk($sformatf("t5_x%0d", i), x, co_x[i]);
        end
        tk();
        chk("t5_idle_x", x, 33);
        chk("t5_idle_spd", int'(spd), 0);

        // Right screen edge clamp
        left  = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tk();
            if (blk) found = 1;
        end
        chk("edge_hit", found, 1);
        chk("edge_x", x, 598);
        chk("edge_spd", int'(spd), 0);

        // 6: async reset mid-run at speed 3
        right = 1'b0;
        left  = 1'b1;
        repeat (13) tk();
        chk("t6_spd3", int'(spd), 3);
        chk("t6_x577", x, 577);
        chk("t6_fl1", int'(fl), 1);
        @(negedge clk);
        tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_x", x, 100);
        chk("t6_rst_spd", int'(spd), 0);
        chk("t6_rst_fl", int'(fl), 0);
        chk("t6_rst_blk", int'(blk), 0);
        @(negedge clk);
        tick = 1'b0;
        chk("t6_rst_hold", x, 100);
        rst_n = 1'b1;

        // Sprite above the map: solid tiles in rows 0 and 11 are not seen
        y = -50;
        bg[0][1]  = GND;
        bg[11][1] = GND;
        seen = 0;
        for (int i = 0; i < 13; i++) begin
            tk();
            if (blk) seen = 1;
        end
        chk("t6_noblk", seen, 0);
        chk("t6_x79", x, 79);
        chk("t6_spd", int'(spd), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
